// File: rtl/loader_pkg.sv
// Shared definitions for the boot loader: command op encodings, loader state and a width helper.
package loader_pkg;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_DONE  = 2'b01;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

   // A single target memory still gets a 1-bit select field.
   function automatic int sel_width(input int num_mem);
      return (num_mem > 1) ? $clog2(num_mem) : 1;
   endfunction

endpackage

// File: rtl/boot_loader_sync_fifo.sv
// Synchronous FIFO with full/empty flags and a flush input; head entry is read combinationally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign rdata = store[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         store[wr_ptr[PTR_W-1:0]] <= wdata;
   end

endmodule

// File: rtl/boot_loader.sv
// Reset-time program loader: buffers WRITE/DONE commands and streams words into NUM_MEM memories.
// Optional DONE checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module boot_loader
   import loader_pkg::*;
#(
   parameter  int DATA_W     = 32,
   parameter  int ADDR_W     = 10,
   parameter  int NUM_MEM    = 2,
   parameter  int FIFO_DEPTH = 4,
   localparam int SEL_W      = sel_width(NUM_MEM),
   localparam int CNT_W      = ADDR_W + SEL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [SEL_W-1:0]  cmd_sel,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic [NUM_MEM-1:0] mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              core_rst,
   output logic              load_done,
   output logic              load_err,
   output logic [CNT_W-1:0]  word_count
);

   typedef struct packed {
      logic [1:0]        op;
      logic [SEL_W-1:0]  sel;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   state_e state, state_nxt;
   entry_t push_ent, head;
   logic   fifo_full, fifo_empty;
   logic   push, pop;
   logic   done_queued;
   logic   sel_ok, sum_ok;
   logic   write_pop, err_pop;

   assign cmd_ready = (state == ST_LOAD) && !fifo_full && !done_queued;
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == ST_LOAD) && !fifo_empty;
   assign push_ent  = '{op: cmd_op, sel: cmd_sel, addr: cmd_addr, data: cmd_data};

   // Widened compare so a select field that cannot exceed NUM_MEM still lints cleanly.
   assign sel_ok = ({1'b0, head.sel} < (SEL_W+1)'(NUM_MEM));

   sync_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (err_pop),
      .push  (push),
      .wdata (push_ent),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;

   assign sum_ok = (head.data == checksum);

   always_ff @(posedge clk) begin
      if (rst)
         checksum <= '0;
      else if (write_pop)
         checksum <= checksum + head.data;
   end
`else
   assign sum_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= ST_LOAD;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      write_pop = 1'b0;
      err_pop   = 1'b0;
      if (pop) begin
         if (head.op == OP_WRITE) begin
            if (sel_ok) begin
               write_pop = 1'b1;
            end else begin
               err_pop   = 1'b1;
               state_nxt = ST_ERR;
            end
         end else if (head.op == OP_DONE) begin
            if (sum_ok) begin
               state_nxt = ST_RUN;
            end else begin
               err_pop   = 1'b1;
               state_nxt = ST_ERR;
            end
         end else begin
            err_pop   = 1'b1;
            state_nxt = ST_ERR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_queued <= 1'b0;
         mem_we      <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         core_rst    <= 1'b1;
         load_done   <= 1'b0;
         load_err    <= 1'b0;
         word_count  <= '0;
      end else begin
         if (push && (cmd_op == OP_DONE))
            done_queued <= 1'b1;
         mem_we <= '0;
         if (write_pop) begin
            mem_we    <= NUM_MEM'(1) << head.sel;
            mem_addr  <= head.addr;
            mem_wdata <= head.data;
            if (word_count != '1)
               word_count <= word_count + 1'b1;
         end
         if ((state == ST_LOAD) && (state_nxt == ST_RUN)) begin
            load_done <= 1'b1;
            core_rst  <= 1'b0;
         end
         if (err_pop)
            load_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed scenarios plus randomized command streams vs a command-level model.
module tb_boot_loader;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 4;
   localparam int NUM_MEM = 3;
   localparam int DEPTH   = 4;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = ADDR_W + SEL_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   typedef struct {
      logic [1:0]  op;
      int          sel;
      int          addr;
      logic [31:0] data;
   } cmd_t;

   typedef struct {
      int          sel;
      int          addr;
      logic [31:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = '0;
   logic [SEL_W-1:0]  cmd_sel = '0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [DATA_W-1:0] cmd_data = '0;
   logic [NUM_MEM-1:0] mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              core_rst;
   logic              load_done;
   logic              load_err;
   logic [CNT_W-1:0]  word_count;

   int   checks = 0;
   int   errors = 0;
   cmd_t cmd_q[$];
   wr_t  exp_q[$];

   boot_loader #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .NUM_MEM    (NUM_MEM),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_sel    (cmd_sel),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_rst   (core_rst),
      .load_done  (load_done),
      .load_err   (load_err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic cmd_t mk(input logic [1:0] op, input int sel, input int addr, input logic [31:0] data);
      cmd_t c;
      c.op = op; c.sel = sel; c.addr = addr; c.data = data;
      return c;
   endfunction

   // Every issued write must be the next one the model expects, in order.
   always @(negedge clk) begin
      wr_t w;
      if (mem_we !== '0) begin
         if (exp_q.size() == 0) begin
            chk("extra_we", 64'(mem_we), 64'd0);
         end else begin
            w = exp_q.pop_front();
            chk("we", 64'(mem_we), 64'(3'b001 << w.sel));
            chk("addr", 64'(mem_addr), 64'(w.addr));
            chk("wdata", 64'(mem_wdata), 64'(w.data));
         end
      end
   end

   task automatic do_reset();
      exp_q.delete();
      cmd_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_core_rst", 64'(core_rst), 64'd1);
      chk("rst_done", 64'(load_done), 64'd0);
      chk("rst_err", 64'(load_err), 64'd0);
      chk("rst_count", 64'(word_count), 64'd0);
      chk("rst_ready", 64'(cmd_ready), 64'd1);
   endtask

   // Command-level model: walks the stream until the first terminating command.
   task automatic model(output int cnt, output bit done, output bit err);
      logic [31:0] sum;
      sum = '0; cnt = 0; done = 1'b0; err = 1'b0;
      foreach (cmd_q[i]) begin
         if (done || err) break;
         if (cmd_q[i].op == 2'b00 && cmd_q[i].sel < NUM_MEM) begin
            exp_q.push_back('{sel: cmd_q[i].sel, addr: cmd_q[i].addr, data: cmd_q[i].data});
            if (cnt < CNT_MAX) cnt++;
            sum += cmd_q[i].data;
         end else if (cmd_q[i].op == 2'b01) begin
            if (!CSUM_ON || cmd_q[i].data == sum) done = 1'b1;
            else err = 1'b1;
         end else begin
            err = 1'b1;
         end
      end
   endtask

   task automatic send(input cmd_t c);
      int n;
      bit acc;
      n = 0; acc = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = c.op;
      cmd_sel   = SEL_W'(c.sel);
      cmd_addr  = ADDR_W'(c.addr);
      cmd_data  = c.data;
      while (!acc && n < 100) begin
         acc = cmd_ready;
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b0;
      chk("send_accept", 64'(acc), 64'd1);
   endtask

   task automatic play(input int max_gap);
      foreach (cmd_q[i]) begin
         send(cmd_q[i]);
         repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      end
   endtask

   task automatic finish_check(input int cnt, input bit done, input bit err);
      repeat (DEPTH + 4) @(negedge clk);
      chk("end_count", 64'(word_count), 64'(cnt));
      chk("end_done", 64'(load_done), 64'(done));
      chk("end_err", 64'(load_err), 64'(err));
      chk("end_core_rst", 64'(core_rst), 64'(!done));
      chk("end_ready", 64'(cmd_ready), 64'(!(done || err)));
      chk("end_pending", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run_case(input int max_gap);
      int  cnt;
      bit  done, err;
      model(cnt, done, err);
      play(max_gap);
      finish_check(cnt, done, err);
   endtask

   task automatic gen_random();
      logic [31:0] s, d;
      bit  term;
      int  n, r;
      s = '0; term = 1'b0;
      n = $urandom_range(12, 1);
      cmd_q.delete();
      for (int k = 0; k < n && !term; k++) begin
         r = $urandom_range(15, 0);
         if (r == 0) begin
            cmd_q.push_back(mk(2'($urandom_range(3, 2)), 0, 0, 32'd0));
            term = 1'b1;
         end else if (r == 1) begin
            cmd_q.push_back(mk(2'b00, 3, $urandom_range(15, 0), $urandom));
            term = 1'b1;
         end else begin
            d = $urandom;
            cmd_q.push_back(mk(2'b00, $urandom_range(2, 0), $urandom_range(3, 0), d));
            s += d;
         end
      end
      if (!term)
         cmd_q.push_back(mk(2'b01, 0, 0, s + 32'($urandom_range(1, 0))));
   endtask

   initial begin
      int  cnt;
      bit  done, err;

      // Basic load with one-cycle FIFO + one-cycle output latency.
      do_reset();
      cmd_q = '{mk(2'b00, 0, 0, 32'h0000_E819), mk(2'b00, 1, 3, 32'hFFFF_FFF9),
                mk(2'b01, 0, 0, 32'h0000_E812)};
      model(cnt, done, err);
      send(cmd_q[0]);
      chk("lat_n1_we", 64'(mem_we), 64'd0);
      @(negedge clk);
      chk("lat_n2_we", 64'(mem_we), 64'b001);
      send(cmd_q[1]);
      send(cmd_q[2]);
      chk("done_pending_core_rst", 64'(core_rst), 64'd1);
      @(negedge clk);
      chk("done_core_rst", 64'(core_rst), 64'd0);
      chk("done_flag", 64'(load_done), 64'd1);
      finish_check(cnt, done, err);

      // Commands after RUN are refused and issue nothing.
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_sel = 2'd1; cmd_addr = 4'd9; cmd_data = 32'h1234_5678;
      repeat (3) begin
         @(negedge clk);
         chk("run_ready", 64'(cmd_ready), 64'd0);
      end
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("run_count", 64'(word_count), 64'd2);

      // Ten back-to-back writes with a rewrite of the same address.
      do_reset();
      cmd_q.delete();
      for (int i = 0; i < 10; i++)
         cmd_q.push_back(mk(2'b00, i % 3, (i * 5) % 8, 32'hA000_0000 + 32'(i)));
      run_case(0);

      // Bad select, then a write already buffered behind it that must be flushed.
      do_reset();
      cmd_q = '{mk(2'b00, 1, 5, 32'h1111_1111), mk(2'b00, 3, 6, 32'h2222_2222),
                mk(2'b00, 0, 7, 32'h3333_3333)};
      run_case(0);

      // Reserved op.
      do_reset();
      cmd_q = '{mk(2'b00, 2, 1, 32'h4444_4444), mk(2'b10, 0, 0, 32'd0)};
      run_case(1);

      // Reset mid-load: only the first write escapes.
      do_reset();
      exp_q.push_back('{sel: 2, addr: 4, data: 32'hCAFE_0001});
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_sel = 2'd2; cmd_addr = 4'd4; cmd_data = 32'hCAFE_0001;
      @(negedge clk);
      cmd_sel = 2'd0; cmd_addr = 4'd5; cmd_data = 32'hCAFE_0002;
      @(negedge clk);
      cmd_sel = 2'd1; cmd_addr = 4'd6; cmd_data = 32'hCAFE_0003;
      chk("mid_first_we", 64'(mem_we), 64'b100);
      chk("mid_count", 64'(word_count), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; cmd_valid = 1'b0;
      chk("mid_rst_count", 64'(word_count), 64'd0);
      chk("mid_rst_core_rst", 64'(core_rst), 64'd1);
      chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
      finish_check(0, 1'b0, 1'b0);

      // Checksum: 5 + (-7) + 2 == 0.
      do_reset();
      cmd_q = '{mk(2'b00, 0, 1, 32'd5), mk(2'b00, 0, 2, -32'sd7), mk(2'b00, 1, 3, 32'd2),
                mk(2'b01, 0, 0, 32'd0)};
      run_case(1);
      do_reset();
      cmd_q[3].data = 32'd1;
      run_case(1);

      // Counter saturation.
      do_reset();
      cmd_q.delete();
      for (int i = 0; i < CNT_MAX + 7; i++)
         cmd_q.push_back(mk(2'b00, i % 3, i % 16, 32'(i)));
      run_case(0);

      for (int it = 0; it < 10; it++) begin
         do_reset();
         gen_random();
         run_case(2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
